// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB definitions for the SRAM subordinate.
//   trans_t     : HTRANS encoding (codes 4..7 behave as IDLE in the subordinate)
//   RESP_*      : HRESP encoding
//   sub_state_t : subordinate data-phase FSM states
//   misaligned(): byte address not aligned to a 2**size transfer
package ahb_pkg;

  typedef enum logic [2:0] {
    TRANS_IDLE   = 3'd0,
    TRANS_BUSY   = 3'd1,
    TRANS_NONSEQ = 3'd2,
    TRANS_SEQ    = 3'd3
  } trans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sub_state_t;

  // True when any address bit below the transfer size is set.
  function automatic logic misaligned(input logic [63:0] byte_addr, input logic [3:0] size);
    logic [63:0] mask;
    mask = (64'd1 << size) - 64'd1;
    return (byte_addr & mask) != 64'd0;
  endfunction

endpackage

// File: rtl/AHBCommon_if.sv
// AHBCommon_if: AHB bus bundle between a manager and one subordinate.
//   master      : drives sel/addr/trans/write/size/burst/prot/mastLock/ready/
//                 wData/wStrb/excl, observes readyOut/resp/rData/exOkay
//   subordinate : the mirror view used by responders
interface AHBCommon_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                   sel;
  logic [AddrWidth-1:0]   addr;
  logic [2:0]             trans;
  logic                   write;
  logic [3:0]             size;
  logic [2:0]             burst;
  logic [3:0]             prot;
  logic                   mastLock;
  logic                   ready;
  logic [DataWidth-1:0]   wData;
  logic [DataWidth/8-1:0] wStrb;
  logic                   excl;
  logic                   readyOut;
  logic                   resp;
  logic [DataWidth-1:0]   rData;
  logic                   exOkay;

  modport master (
    output sel, addr, trans, write, size, burst, prot, mastLock, ready, wData, wStrb, excl,
    input  readyOut, resp, rData, exOkay
  );

  modport subordinate (
    input  sel, addr, trans, write, size, burst, prot, mastLock, ready, wData, wStrb, excl,
    output readyOut, resp, rData, exOkay
  );
endinterface

// File: rtl/ahb_excl_monitor.sv
// ahb_excl_monitor: single exclusive-access reservation (valid + word index).
//   clk, nReset : clock, synchronous active-low reset
//   set, idx    : open a reservation on word idx (wins over clr)
//   clr         : drop the reservation
//   valid       : reservation held
//   resv_idx    : reserved word index
module ahb_excl_monitor #(
  parameter int IdxWidth = 10
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                set,
  input  logic                clr,
  input  logic [IdxWidth-1:0] idx,
  output logic                valid,
  output logic [IdxWidth-1:0] resv_idx
);

  logic                valid_r;
  logic [IdxWidth-1:0] idx_r;

  // Reservation register; a set in the same cycle as a clear keeps the reservation.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      valid_r <= 1'b0;
      idx_r   <= '0;
    end else if (set) begin
      valid_r <= 1'b1;
      idx_r   <= idx;
    end else if (clr) begin
      valid_r <= 1'b0;
    end
  end

  assign valid    = valid_r;
  assign resv_idx = idx_r;

endmodule

// File: rtl/ahb_sram_sub.sv
// ahb_sram_sub: AHB subordinate fronting a word-addressed SRAM.
//   clk    : clock
//   nReset : synchronous active-low reset (memory contents are kept)
//   bus    : AHBCommon_if.subordinate (address/data phase inputs, readyOut,
//            resp, rData, exOkay outputs)
// Transfers are checked when the address phase is sampled; range, size or
// alignment violations produce the two-cycle ERROR response with no memory
// side effects. Good transfers get WaitStates extra data-phase cycles.
// Optional feature: define AHB_SUB_EXCL_EN for exclusive-access support.
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 1024,
  parameter int WaitStates = 0
) (
  input logic             clk,
  input logic             nReset,
  AHBCommon_if.subordinate bus
);

  localparam int ByteLanes = DataWidth / 8;
  localparam int LaneBits  = $clog2(ByteLanes);
  localparam int WordIdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0] MaxSize = 4'(LaneBits);
  // One extra bit so Depth*ByteLanes never wraps against a full-width address.
  localparam logic [AddrWidth:0] ByteRange = (AddrWidth + 1)'(Depth * ByteLanes);
  localparam logic [3:0] WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
  localparam bit WaitEn = (WaitStates > 0);

  sub_state_t           state_r, state_nxt_s;
  logic [3:0]           cnt_r;
  logic                 dp_valid_r, dp_write_r, dp_excl_r;
  logic [WordIdxW-1:0]  dp_word_r;
  logic [DataWidth-1:0] rdata_r;
  logic [DataWidth-1:0] mem_r [Depth];

  logic                accept_s, sample_s, bad_s;
  logic                final_s, final_rd_s, final_wr_s;
  logic [WordIdxW-1:0] word_s;
  logic                excl_in_s, commit_s, exokay_s, unused_s;

  // ERR2 is also the last cycle of the error response, so it can take the next address.
  assign accept_s = (state_r == ST_IDLE) || (state_r == ST_ERR2);
  assign sample_s = accept_s && bus.sel && bus.ready &&
                    ((bus.trans == TRANS_NONSEQ) || (bus.trans == TRANS_SEQ));
  assign bad_s    = ({1'b0, bus.addr} >= ByteRange) || (bus.size > MaxSize) ||
                    misaligned(64'(bus.addr), bus.size);
  assign word_s   = WordIdxW'(bus.addr >> LaneBits);

  // A pending good transfer in IDLE is in its final (readyOut=1) data cycle.
  assign final_s    = (state_r == ST_IDLE) && dp_valid_r;
  assign final_rd_s = final_s && !dp_write_r;
  assign final_wr_s = final_s && dp_write_r;

`ifdef AHB_SUB_EXCL_EN
  logic                resv_valid_s, resv_hit_s, resv_set_s, resv_clr_s;
  logic [WordIdxW-1:0] resv_word_s;

  assign excl_in_s  = bus.excl;
  assign resv_hit_s = resv_valid_s && (resv_word_s == dp_word_r);
  assign resv_set_s = final_rd_s && dp_excl_r;
  // Exclusive writes always consume the reservation; normal writes only when they hit it.
  assign resv_clr_s = final_wr_s && (dp_excl_r || resv_hit_s);
  assign commit_s   = !dp_excl_r || resv_hit_s;
  assign exokay_s   = final_s && dp_excl_r && (!dp_write_r || resv_hit_s);
  assign unused_s   = ^{bus.burst, bus.prot, bus.mastLock};

  ahb_excl_monitor #(.IdxWidth(WordIdxW)) u_excl_monitor (
    .clk      (clk),
    .nReset   (nReset),
    .set      (resv_set_s),
    .clr      (resv_clr_s),
    .idx      (dp_word_r),
    .valid    (resv_valid_s),
    .resv_idx (resv_word_s)
  );
`else
  assign excl_in_s = 1'b0;
  assign commit_s  = 1'b1;
  assign exokay_s  = 1'b0;
  assign unused_s  = ^{bus.burst, bus.prot, bus.mastLock, bus.excl, dp_excl_r};
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (sample_s) begin
          if (bad_s) begin
            state_nxt_s = ST_ERR1;
          end else if (WaitEn) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Address-phase capture, wait counter and read-data hold register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      cnt_r      <= 4'd0;
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_excl_r  <= 1'b0;
      dp_word_r  <= '0;
      rdata_r    <= '0;
    end else begin
      if (final_rd_s) begin
        rdata_r <= mem_r[dp_word_r];
      end
      if (sample_s) begin
        dp_valid_r <= !bad_s;
        dp_write_r <= bus.write;
        dp_excl_r  <= excl_in_s;
        dp_word_r  <= word_s;
        cnt_r      <= WaitLoad;
      end else begin
        if (final_s) begin
          dp_valid_r <= 1'b0;
        end
        if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
          cnt_r <= cnt_r - 4'd1;
        end
      end
    end
  end

  // Byte-lane write commit at the close of the final data cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (nReset && final_wr_s && commit_s) begin
      for (int i = 0; i < ByteLanes; i++) begin
        if (bus.wStrb[i]) begin
          mem_r[dp_word_r][8*i +: 8] <= bus.wData[8*i +: 8];
        end
      end
    end
  end

  assign bus.readyOut = (state_r != ST_WAIT) && (state_r != ST_ERR1);
  assign bus.resp     = ((state_r == ST_ERR1) || (state_r == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign bus.rData    = final_rd_s ? mem_r[dp_word_r] : rdata_r;
  assign bus.exOkay   = exokay_s;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// tb_ahb_sram_sub: directed self-checking bench for ahb_sram_sub.
// dut0 runs with zero wait states, dut2 with two; both use a 64-word SRAM.
// Read expectations come from a per-DUT memory model and flow through a
// scoreboard queue: pushed when the read address phase is driven, popped
// in the read's final data cycle.
module tb_ahb_sram_sub;
  import ahb_pkg::*;

  localparam int Depth = 64;

  logic clk = 1'b0;
  logic rst0, rst2;
  int   total = 0, passed = 0, failed = 0;
  logic [31:0] sb [$];
  logic [31:0] model0 [Depth];
  logic [31:0] model2 [Depth];

  always #5 clk = ~clk;

  AHBCommon_if #(.DataWidth(32), .AddrWidth(32)) ifc0 ();
  AHBCommon_if #(.DataWidth(32), .AddrWidth(32)) ifc2 ();

  assign ifc0.ready = ifc0.readyOut;
  assign ifc2.ready = ifc2.readyOut;

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(Depth), .WaitStates(0)) dut0 (
    .clk(clk), .nReset(rst0), .bus(ifc0));
  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(Depth), .WaitStates(2)) dut2 (
    .clk(clk), .nReset(rst2), .bus(ifc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle0;
    ifc0.sel = 1'b0; ifc0.trans = TRANS_IDLE; ifc0.excl = 1'b0;
  endtask

  task automatic idle2;
    ifc2.sel = 1'b0; ifc2.trans = TRANS_IDLE; ifc2.excl = 1'b0;
  endtask

  task automatic addr0(input logic [31:0] a, input logic wr, input logic [3:0] sz, input logic ex);
    ifc0.sel = 1'b1; ifc0.trans = TRANS_NONSEQ; ifc0.addr = a; ifc0.write = wr;
    ifc0.size = sz; ifc0.excl = ex;
  endtask

  task automatic addr2(input logic [31:0] a, input logic wr);
    ifc2.sel = 1'b1; ifc2.trans = TRANS_NONSEQ; ifc2.addr = a; ifc2.write = wr;
    ifc2.size = 4'd2; ifc2.excl = 1'b0;
  endtask

  // One non-pipelined transfer on dut0 with all data-phase checks.
  task automatic xfer0(input string tag, input logic [31:0] a, input logic wr, input logic [3:0] sz,
                       input logic ex, input logic [31:0] wd, input logic [3:0] ws,
                       input logic exp_err, input logic exp_exok, input logic commit);
    addr0(a, wr, sz, ex);
    if (!wr && !exp_err) sb.push_back(model0[a[7:2]]);
    tick;
    idle0;
    ifc0.wData = wd;
    ifc0.wStrb = ws;
    if (exp_err) begin
      chk({tag, "_e1_ready"}, 32'(ifc0.readyOut), 32'd0);
      chk({tag, "_e1_resp"},  32'(ifc0.resp),     32'd1);
      tick;
      chk({tag, "_e2_ready"}, 32'(ifc0.readyOut), 32'd1);
      chk({tag, "_e2_resp"},  32'(ifc0.resp),     32'd1);
      tick;
      chk({tag, "_after_resp"}, 32'(ifc0.resp), 32'd0);
    end else begin
      chk({tag, "_ready"}, 32'(ifc0.readyOut), 32'd1);
      chk({tag, "_resp"},  32'(ifc0.resp),     32'd0);
      chk({tag, "_exok"},  32'(ifc0.exOkay),   32'(exp_exok));
      if (!wr) pop_check({tag, "_rdata"}, ifc0.rData);
      else if (commit) model0[a[7:2]] = merge(model0[a[7:2]], wd, ws);
      tick;
    end
  endtask

  // One full-word transfer on dut2: two wait cycles, then the final cycle.
  task automatic xfer2(input string tag, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    addr2(a, wr);
    if (!wr) sb.push_back(model2[a[7:2]]);
    tick;
    idle2;
    ifc2.wData = wd;
    ifc2.wStrb = 4'hF;
    chk({tag, "_w1_ready"}, 32'(ifc2.readyOut), 32'd0);
    chk({tag, "_w1_resp"},  32'(ifc2.resp),     32'd0);
    tick;
    chk({tag, "_w2_ready"}, 32'(ifc2.readyOut), 32'd0);
    tick;
    chk({tag, "_fin_ready"}, 32'(ifc2.readyOut), 32'd1);
    chk({tag, "_fin_resp"},  32'(ifc2.resp),     32'd0);
    if (!wr) pop_check({tag, "_rdata"}, ifc2.rData);
    else model2[a[7:2]] = wd;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b0; rst2 = 1'b0;
    ifc0.addr = 32'd0; ifc0.write = 1'b0; ifc0.size = 4'd2; ifc0.burst = 3'd0; ifc0.prot = 4'd0;
    ifc0.mastLock = 1'b0; ifc0.wData = 32'd0; ifc0.wStrb = 4'd0;
    ifc2.addr = 32'd0; ifc2.write = 1'b0; ifc2.size = 4'd2; ifc2.burst = 3'd0; ifc2.prot = 4'd0;
    ifc2.mastLock = 1'b0; ifc2.wData = 32'd0; ifc2.wStrb = 4'd0;
    idle0; idle2;
    tick; tick; tick;

    // Reset state.
    chk("rst0_ready", 32'(ifc0.readyOut), 32'd1);
    chk("rst0_resp",  32'(ifc0.resp),     32'd0);
    chk("rst0_rdata", ifc0.rData,         32'd0);
    chk("rst0_exok",  32'(ifc0.exOkay),   32'd0);
    chk("rst2_ready", 32'(ifc2.readyOut), 32'd1);
    chk("rst2_rdata", ifc2.rData,         32'd0);
    rst0 = 1'b1; rst2 = 1'b1;
    tick;

    // 1: zero-wait write then read.
    xfer0("t1w", 32'h10, 1'b1, 4'd2, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1);
    xfer0("t1r", 32'h10, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_rdata_hold", ifc0.rData, 32'hDEADBEEF);

    // 3: strobed write over all-ones, then byte write at the top lane.
    xfer0("t3w0", 32'h0, 1'b1, 4'd2, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 1'b1);
    xfer0("t3w1", 32'h0, 1'b1, 4'd2, 1'b0, 32'h11223344, 4'b0101, 1'b0, 1'b0, 1'b1);
    xfer0("t3r",  32'h0, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    xfer0("t3wb", 32'h3, 1'b1, 4'd0, 1'b0, 32'hAB000000, 4'b1000, 1'b0, 1'b0, 1'b1);
    xfer0("t3rb", 32'h0, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Last word of the array is legal.
    xfer0("tlw", 32'hFC, 1'b1, 4'd2, 1'b0, 32'h600DCAFE, 4'hF, 1'b0, 1'b0, 1'b1);
    xfer0("tlr", 32'hFC, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // 4: error responses, no side effects.
    xfer0("t4oob",  32'h100, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    xfer0("t4mis",  32'h2,   1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    xfer0("t4wmis", 32'h2,   1'b1, 4'd2, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    xfer0("t4wsz",  32'h0,   1'b1, 4'd3, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    xfer0("t4woob", 32'h100, 1'b1, 4'd2, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    xfer0("t4r",    32'h0,   1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    xfer0("t4rl",   32'hFC,  1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // 5: back-to-back write then read of the same word.
    addr0(32'h8, 1'b1, 4'd2, 1'b0);
    tick;
    ifc0.wData = 32'h5A5AA5A5;
    ifc0.wStrb = 4'hF;
    model0[2] = 32'h5A5AA5A5;
    addr0(32'h8, 1'b0, 4'd2, 1'b0);
    sb.push_back(model0[2]);
    chk("t5_w_ready", 32'(ifc0.readyOut), 32'd1);
    tick;
    idle0;
    chk("t5_r_ready", 32'(ifc0.readyOut), 32'd1);
    pop_check("t5_rdata", ifc0.rData);
    tick;

    // 6: exclusive accesses.
    xfer0("t6w0", 32'h20, 1'b1, 4'd2, 1'b0, 32'h01010101, 4'hF, 1'b0, 1'b0, 1'b1);
`ifdef AHB_SUB_EXCL_EN
    xfer0("t6xr",  32'h20, 1'b0, 4'd2, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    xfer0("t6xw",  32'h20, 1'b1, 4'd2, 1'b1, 32'h02020202, 4'hF, 1'b0, 1'b1, 1'b1);
    xfer0("t6r",   32'h20, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    xfer0("t6xr2", 32'h20, 1'b0, 4'd2, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    xfer0("t6nw",  32'h20, 1'b1, 4'd2, 1'b0, 32'h03030303, 4'hF, 1'b0, 1'b0, 1'b1);
    xfer0("t6xw2", 32'h20, 1'b1, 4'd2, 1'b1, 32'h04040404, 4'hF, 1'b0, 1'b0, 1'b0);
    xfer0("t6r2",  32'h20, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
`else
    xfer0("t6xr",  32'h20, 1'b0, 4'd2, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    xfer0("t6xw",  32'h20, 1'b1, 4'd2, 1'b1, 32'h02020202, 4'hF, 1'b0, 1'b0, 1'b1);
    xfer0("t6r",   32'h20, 1'b0, 4'd2, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
`endif

    // 2: two wait states.
    xfer2("t2w", 32'h4, 1'b1, 32'h0BADF00D);
    xfer2("t2r", 32'h4, 1'b0, 32'h0);

    // 7: reset in the middle of a waited write drops the write.
    xfer2("t7w", 32'hC, 1'b1, 32'h12345678);
    addr2(32'hC, 1'b1);
    tick;
    idle2;
    ifc2.wData = 32'hCAFEF00D;
    ifc2.wStrb = 4'hF;
    chk("t7_wait_ready", 32'(ifc2.readyOut), 32'd0);
    rst2 = 1'b0;
    tick;
    chk("t7_rst_ready", 32'(ifc2.readyOut), 32'd1);
    chk("t7_rst_resp",  32'(ifc2.resp),     32'd0);
    chk("t7_rst_rdata", ifc2.rData,         32'd0);
    rst2 = 1'b1;
    tick;
    tick;
    xfer2("t7r", 32'hC, 1'b0, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
